seg7_scan_reader: RTL and testbench

- Reader side of the multiplexed 7-segment display interface. Passively samples the active-low segment bus and active-low digit anodes driven by the display path, and reconstructs one BCD code per digit.
- Used for display loop-back checking and for panel-capture on the board. It is the inverse of the BCD-to-segment encoding, with scan timing, settling and error flagging added.

---
 rtl/seg7_pkg.sv | 26 ++
 rtl/seg7_pattern_decode.sv | 39 +++
 rtl/seg7_scan_reader.sv | 191 +++++++++++++++++++
 tb/tb_seg7_scan_reader.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared encodings for the 7-segment reader: active-low segment patterns (bit6=a .. bit0=g),
// special output codes and the scan FSM state type.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] CODE_BLANK = 4'hF;
    localparam logic [3:0] CODE_ERR   = 4'hE;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HOLD
    } state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Active-low 7-segment pattern to BCD code; purely combinational, zero latency.
// No flow control: valid marks a 0-9 digit, err marks a pattern that is neither a digit nor blank.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] code,
    output logic       valid,
    output logic       err
);

    always_comb begin
        code  = CODE_ERR;
        valid = 1'b1;
        err   = 1'b0;
        case (pattern)
            SEG_0: code = 4'd0;
            SEG_1: code = 4'd1;
            SEG_2: code = 4'd2;
            SEG_3: code = 4'd3;
            SEG_4: code = 4'd4;
            SEG_5: code = 4'd5;
            SEG_6: code = 4'd6;
            SEG_7: code = 4'd7;
            SEG_8: code = 4'd8;
            SEG_9: code = 4'd9;
            SEG_BLANK: begin
                code  = CODE_BLANK;
                valid = 1'b0;
            end
            default: begin
                code  = CODE_ERR;
                valid = 1'b0;
                err   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/seg7_scan_reader.sv
// Passive reader of a multiplexed 7-seg display; capture lands STABLE_CYCLES+2 edges after inputs settle.
// No backpressure (sampling only); SEG7_DP_CAPTURE_EN adds decimal-point capture (dp_n / dp_out).
module seg7_scan_reader
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [6:0]                seg_n,
    input  logic [NUM_DIGITS-1:0]     an_n,
`ifdef SEG7_DP_CAPTURE_EN
    input  logic                      dp_n,
    output logic [NUM_DIGITS-1:0]     dp_out,
`endif
    output logic [4*NUM_DIGITS-1:0]   bcd_digits,
    output logic [NUM_DIGITS-1:0]     digit_valid,
    output logic                      seg_err,
    output logic                      frame_done
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
`ifdef SEG7_DP_CAPTURE_EN
    localparam int BUS_W = 8;
`else
    localparam int BUS_W = 7;
`endif

    logic [BUS_W-1:0] bus_in;
`ifdef SEG7_DP_CAPTURE_EN
    assign bus_in = {dp_n, seg_n};
`else
    assign bus_in = seg_n;
`endif

    logic [BUS_W-1:0]        seg_meta_d, seg_meta_q, seg_sync_d, seg_sync_q, prev_seg_d, prev_seg_q;
    logic [NUM_DIGITS-1:0]   an_meta_d, an_meta_q, an_sync_d, an_sync_q, prev_an_d, prev_an_q;
    state_t                  state_d, state_q;
    logic [7:0]              cnt_d, cnt_q;
    logic [4*NUM_DIGITS-1:0] bcd_d, bcd_q;
    logic [NUM_DIGITS-1:0]   vld_d, vld_q, set_d, set_q;
    logic                    err_d, err_q, frame_d, frame_q;
    logic [3:0]              low_cnt;
    logic [IDX_W-1:0]        dig_idx;
    logic                    scan_ok, seg_same, an_same, capture, set_full;
    logic [3:0]              dec_code;
    logic                    dec_vld, dec_err;

    // Two-flop synchronizers plus a one-cycle history used for the stability compare.
    always_comb begin
        seg_meta_d = bus_in;
        seg_sync_d = seg_meta_q;
        an_meta_d  = an_n;
        an_sync_d  = an_meta_q;
        prev_seg_d = seg_sync_q;
        prev_an_d  = an_sync_q;
    end

    always_comb begin
        low_cnt = 4'd0;
        dig_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!an_sync_q[i]) begin
                low_cnt = low_cnt + 4'd1;
                dig_idx = IDX_W'(i);
            end
        end
    end

    assign scan_ok  = (low_cnt == 4'd1);
    assign seg_same = (seg_sync_q == prev_seg_q);
    assign an_same  = (an_sync_q == prev_an_q);
    assign set_full = &set_q;

    seg7_pattern_decode u_decode (
        .pattern (seg_sync_q[6:0]),
        .code    (dec_code),
        .valid   (dec_vld),
        .err     (dec_err)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (scan_ok) begin
                    state_d = SETTLE;
                    cnt_d   = 8'd1;
                end
            end
            SETTLE: begin
                if (!seg_same || !an_same || !scan_ok) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end else if (cnt_q >= 8'(STABLE_CYCLES)) begin
                    capture = 1'b1;
                    state_d = HOLD;
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            HOLD: begin
                // Only an anode change ends the dwell; a new legal anode starts settling at once.
                if (!an_same) begin
                    state_d = scan_ok ? SETTLE : IDLE;
                    cnt_d   = scan_ok ? 8'd1 : 8'd0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_comb begin
        bcd_d   = bcd_q;
        vld_d   = vld_q;
        err_d   = 1'b0;
        frame_d = set_full;
        set_d   = set_full ? '0 : set_q;
        if (capture) begin
            bcd_d[4*dig_idx +: 4] = dec_code;
            vld_d[dig_idx]        = dec_vld;
            err_d                 = dec_err;
            set_d[dig_idx]        = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_meta_q <= '1;
            seg_sync_q <= '1;
            prev_seg_q <= '1;
            an_meta_q  <= '1;
            an_sync_q  <= '1;
            prev_an_q  <= '1;
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            bcd_q      <= '1;
            vld_q      <= '0;
            set_q      <= '0;
            err_q      <= 1'b0;
            frame_q    <= 1'b0;
        end else begin
            seg_meta_q <= seg_meta_d;
            seg_sync_q <= seg_sync_d;
            prev_seg_q <= prev_seg_d;
            an_meta_q  <= an_meta_d;
            an_sync_q  <= an_sync_d;
            prev_an_q  <= prev_an_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bcd_q      <= bcd_d;
            vld_q      <= vld_d;
            set_q      <= set_d;
            err_q      <= err_d;
            frame_q    <= frame_d;
        end
    end

`ifdef SEG7_DP_CAPTURE_EN
    logic [NUM_DIGITS-1:0] dp_d, dp_q;

    always_comb begin
        dp_d = dp_q;
        if (capture) begin
            dp_d[dig_idx] = ~seg_sync_q[7];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_q <= '0;
        end else begin
            dp_q <= dp_d;
        end
    end

    assign dp_out = dp_q;
`endif

    assign bcd_digits  = bcd_q;
    assign digit_valid = vld_q;
    assign seg_err     = err_q;
    assign frame_done  = frame_q;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Randomized dwell-level stimulus for seg7_scan_reader with a queue-based scoreboard
// fed by a behavioural display model; a separate monitor compares every visible output event.
module tb_seg7_scan_reader;

    localparam int ND = 4;
    localparam int SC = 8;

    typedef struct packed {
        logic [4*ND-1:0] bcd;
        logic [ND-1:0]   vld;
        logic            err;
    } rec_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [6:0]        seg_n = 7'h7F;
    logic [ND-1:0]     an_n = '1;
    logic [4*ND-1:0]   bcd_digits;
    logic [ND-1:0]     digit_valid;
    logic              seg_err;
    logic              frame_done;
`ifdef SEG7_DP_CAPTURE_EN
    logic              dp_n = 1'b1;
    logic [ND-1:0]     dp_out;
`endif

    always #5 clk = ~clk;

    seg7_scan_reader #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_n       (seg_n),
        .an_n        (an_n),
`ifdef SEG7_DP_CAPTURE_EN
        .dp_n        (dp_n),
        .dp_out      (dp_out),
`endif
        .bcd_digits  (bcd_digits),
        .digit_valid (digit_valid),
        .seg_err     (seg_err),
        .frame_done  (frame_done)
    );

    // Digit glyphs as a lookup table, index = displayed value.
    logic [6:0] glyph [0:9] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

    int n_cmp = 0;
    int n_bad = 0;
    bit mon_en = 1'b0;
    rec_t            exp_q [$];
    logic [4*ND-1:0] frm_q [$];

    // Display model: what the panel shows, which digits have been seen this frame,
    // and whether the current anode dwell has already produced its capture.
    logic [4*ND-1:0] m_bcd = '1;
    logic [ND-1:0]   m_vld = '0;
    logic [ND-1:0]   m_set = '0;
    bit              m_hold = 1'b0;
    logic [ND-1:0]   m_prev_an = '1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_capture(input int d, input logic [6:0] seg);
        logic [3:0] code = 4'hE;
        logic       v = 1'b0;
        logic       e = 1'b1;
        logic [4*ND-1:0] old_bcd = m_bcd;
        logic [ND-1:0]   old_vld = m_vld;
        if (seg == 7'h7F) begin
            code = 4'hF;
            e    = 1'b0;
        end
        for (int k = 0; k < 10; k++) begin
            if (glyph[k] == seg) begin
                code = 4'(k);
                v    = 1'b1;
                e    = 1'b0;
            end
        end
        m_bcd[4*d +: 4] = code;
        m_vld[d]        = v;
        if (e || m_bcd != old_bcd || m_vld != old_vld)
            exp_q.push_back('{bcd: m_bcd, vld: m_vld, err: e});
        m_set[d] = 1'b1;
        if (&m_set) begin
            frm_q.push_back(m_bcd);
            m_set = '0;
        end
    endtask

    // A dwell holds one anode/segment combination for len cycles. Lengths are kept at
    // <= SC (never captures) or >= SC+2 (always captures unless the dwell continues a held anode).
    task automatic apply(input logic [ND-1:0] an, input logic [6:0] seg, input int len);
        int  lows = 0;
        int  d = 0;
        bit  cap;
        bit  cont;
        for (int i = 0; i < ND; i++) begin
            if (!an[i]) begin
                lows++;
                d = i;
            end
        end
        cont = (an == m_prev_an) && m_hold;
        if (lows != 1) begin
            cap    = 1'b0;
            m_hold = 1'b0;
        end else begin
            cap    = !cont && (len >= SC + 2);
            m_hold = cap || cont;
        end
        m_prev_an = an;
        if (cap) model_capture(d, seg);
        an_n  = an;
        seg_n = seg;
    endtask

    task automatic dwell(input logic [ND-1:0] an, input logic [6:0] seg, input int len);
        apply(an, seg, len);
        repeat (len) @(posedge clk);
        #1;
    endtask

    // Checks the exact capture edge: unchanged after edge t+SC+1, updated after edge t+SC+2.
    task automatic timed_capture(input logic [ND-1:0] an, input logic [6:0] seg, input int len);
        logic [4*ND-1:0] pre = m_bcd;
        apply(an, seg, len);
        repeat (SC + 2) @(posedge clk);
        @(negedge clk);
        check("pre_capture_bcd", 32'(bcd_digits), 32'(pre));
        @(posedge clk);
        @(negedge clk);
        check("capture_edge_bcd", 32'(bcd_digits), 32'(m_bcd));
        check("capture_edge_vld", 32'(digit_valid), 32'(m_vld));
        repeat (len - (SC + 3)) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_bcd"}, 32'(bcd_digits), 32'hFFFF);
        check({tag, "_vld"}, 32'(digit_valid), 32'h0);
        check({tag, "_err"}, 32'(seg_err), 32'h0);
        check({tag, "_frame"}, 32'(frame_done), 32'h0);
    endtask

    // Monitor: any output change, error pulse or frame pulse must match the next expectation.
    initial begin
        logic [4*ND-1:0] last_bcd;
        logic [ND-1:0]   last_vld;
        rec_t            r;
        logic [4*ND-1:0] f;
        wait (mon_en);
        last_bcd = bcd_digits;
        last_vld = digit_valid;
        forever begin
            @(negedge clk);
            if (seg_err || bcd_digits != last_bcd || digit_valid != last_vld) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_event: got bcd=%h vld=%b err=%b expected no event",
                             bcd_digits, digit_valid, seg_err);
                end else begin
                    r = exp_q.pop_front();
                    check("capture_event", 32'({bcd_digits, digit_valid, seg_err}),
                          32'({r.bcd, r.vld, r.err}));
                end
            end
            last_bcd = bcd_digits;
            last_vld = digit_valid;
            if (frame_done) begin
                if (frm_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_frame: got frame_done=1 expected 0 (bcd=%h)", bcd_digits);
                end else begin
                    f = frm_q.pop_front();
                    check("frame_snapshot", 32'(bcd_digits), 32'(f));
                end
            end
        end
    end

    initial begin
        logic [ND-1:0] an;
        logic [6:0]    seg;
        int            len;
        int            r;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // Single digit, exact latency.
        timed_capture(4'b1110, glyph[2], 20);
        check("other_digits_blank", 32'(bcd_digits[15:4]), 32'hFFF);

        // Full scan 1,2,3,4 -> one frame.
        dwell(4'b1111, 7'h7F, 4);
        for (int i = 0; i < 4; i++)
            dwell(~(4'b0001 << i), glyph[i+1], 16);
        dwell(4'b1111, 7'h7F, 6);
        check("scan_bcd", 32'(bcd_digits), 32'h4321);
        check("scan_vld", 32'(digit_valid), 32'hF);

        // Segment glitching under one anode never settles.
        for (int i = 0; i < 6; i++)
            dwell(4'b1011, (i % 2 == 0) ? glyph[7] : glyph[8], 5);

        // Illegal pattern then blank on digit 1.
        dwell(4'b1101, 7'b1111110, 16);
        dwell(4'b1111, 7'h7F, 4);
        dwell(4'b1101, 7'h7F, 16);

        // Two anodes low: illegal scan.
        dwell(4'b1100, glyph[5], 20);

        // Reset in the middle of settling.
        apply(4'b0111, glyph[7], 5);
        repeat (5) @(posedge clk);
        #1;
        if (m_bcd != '1 || m_vld != '0)
            exp_q.push_back('{bcd: '1, vld: '0, err: 1'b0});
        m_bcd = '1; m_vld = '0; m_set = '0; m_hold = 1'b0; m_prev_an = '1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_settle_reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        timed_capture(4'b0111, glyph[7], 20);

        // Random dwells.
        for (int n = 0; n < 150; n++) begin
            do begin
                r = $urandom_range(0, 99);
                if (r < 70)      an = ~(4'b0001 << $urandom_range(0, 3));
                else if (r < 85) an = 4'b1111;
                else             an = 4'($urandom);
                r = $urandom_range(0, 99);
                if (r < 60)      seg = glyph[$urandom_range(0, 9)];
                else if (r < 75) seg = 7'h7F;
                else             seg = 7'($urandom);
            end while (an == an_n && seg == seg_n);
            len = ($urandom_range(0, 1) == 1) ? $urandom_range(2, SC) : $urandom_range(SC + 2, 2 * SC + 4);
            dwell(an, seg, len);
        end

        dwell(4'b1111, 7'h7F, 3 * SC);
        check("final_bcd", 32'(bcd_digits), 32'(m_bcd));
        check("final_vld", 32'(digit_valid), 32'(m_vld));
        check("pending_events", 32'(exp_q.size()), 32'd0);
        check("pending_frames", 32'(frm_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
